mac_accum_unit: RTL and testbench

- Sequential signed multiply-accumulate engine for the matrix MAC datapath.
- Consumes LEN operand pairs over a valid/ready stream and accumulates their products into a 32-bit dot product.
- Holds the result behind a valid/ready handshake.
- `result` drives the MAC-result (s=1) input of the 32-bit 2:1 writeback select mux, directly upstream of it.

---
 rtl/mac_accum_unit_if.sv | 23 ++
 rtl/mac_accum_unit.sv | 118 +++++++++++
 tb/tb_mac_accum_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mac_accum_unit_if.sv
// Operand and result stream bundle for mac_accum_unit.
// The master drives operand pairs and takes results; the slave is the MAC unit.
interface mac_accum_unit_if #(
    parameter int DATA_W = 32
);
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] result;

    modport master (
        output op_valid, op_a, op_b, res_ready,
        input  op_ready, res_valid, result
    );

    modport slave (
        input  op_valid, op_a, op_b, res_ready,
        output op_ready, res_valid, result
    );
endinterface

// File: rtl/mac_accum_unit.sv
// Sequential signed multiply-accumulate: LEN operand pairs in, one DATA_W dot product out.
// Optional MAC_SAT_EN: saturating product and sum with a sticky sat_flag (wrap arithmetic otherwise).
module mac_accum_unit #(
    parameter int DATA_W = 32,
    parameter int LEN    = 4,
    parameter int CNT_W  = $clog2(LEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    mac_accum_unit_if.slave  bus,
    output logic             busy,
    output logic             sat_flag
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;

    logic [DATA_W-1:0]  acc_next;
    logic               sat_event;

`ifdef MAC_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] prod_full;
    logic        [DATA_W-1:0]   prod_sat;
    logic        [DATA_W:0]     sum_ext;
    logic                       prod_ovf;
    logic                       sum_ovf;

    always_comb begin
        prod_full = $signed(bus.op_a) * $signed(bus.op_b);
        // The product fits in DATA_W bits only if its top DATA_W+1 bits are a pure sign extension.
        prod_ovf  = !((&prod_full[2*DATA_W-1:DATA_W-1]) || !(|prod_full[2*DATA_W-1:DATA_W-1]));
        prod_sat  = prod_ovf ? (prod_full[2*DATA_W-1] ? SAT_MIN : SAT_MAX)
                             : prod_full[DATA_W-1:0];
        sum_ext   = {acc_q[DATA_W-1], acc_q} + {prod_sat[DATA_W-1], prod_sat};
        sum_ovf   = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
        acc_next  = sum_ovf ? (sum_ext[DATA_W] ? SAT_MIN : SAT_MAX) : sum_ext[DATA_W-1:0];
        sat_event = prod_ovf | sum_ovf;
    end
`else
    logic [DATA_W-1:0] prod_lo;

    // The low DATA_W bits of a product are identical for signed and unsigned operands.
    assign prod_lo   = bus.op_a * bus.op_b;
    assign acc_next  = acc_q + prod_lo;
    assign sat_event = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        sat_d    = sat_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (bus.op_valid) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (sat_event) sat_d = 1'b1;
                    if (cnt_q == CNT_W'(LEN - 1)) begin
                        state_d  = DONE;
                        result_d = acc_next;
                    end
                end
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

    // Handshake outputs decode the state register only; nothing combinational reaches them.
    assign bus.op_ready  = (state_q == ACCUM);
    assign bus.res_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign busy          = (state_q != IDLE);
    assign sat_flag      = sat_q;
endmodule

// File: tb/tb_mac_accum_unit.sv
// Self-checking bench for mac_accum_unit: vector table plus scoreboard queue of expected results.
// Overflow expectations follow MAC_SAT_EN when the bench is built with it.
module tb_mac_accum_unit;
    localparam int DATA_W = 32;
    localparam int LEN    = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic sat_flag;

    mac_accum_unit_if #(.DATA_W(DATA_W)) bus ();

    mac_accum_unit #(.DATA_W(DATA_W), .LEN(LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                   name;
        logic [0:3][DATA_W-1:0]  a;
        logic [0:3][DATA_W-1:0]  b;
        int                      gap;
        int                      stall;
        bit                      start_in_done;
        bit                      collide;
        logic [DATA_W-1:0]       exp_res;
        logic                    exp_sat;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] res;
        logic              sat;
    } exp_t;

    vec_t tbl [5];
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_dot(input vec_t v);
        exp_t e;
        int   waited;
        start = 1'b1;
        if (v.collide) begin
            bus.op_valid = 1'b1;
            bus.op_a     = 32'd9;
            bus.op_b     = 32'd9;
        end
        tick();
        start        = 1'b0;
        bus.op_valid = 1'b0;
        check({v.name, ".busy_accum"}, 32'(busy), 32'd1);
        check({v.name, ".ready_accum"}, 32'(bus.op_ready), 32'd1);
        exp_q.push_back('{res: v.exp_res, sat: v.exp_sat});

        for (int i = 0; i < LEN; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    tick();
                    check({v.name, ".ready_gap"}, 32'(bus.op_ready), 32'd1);
                    check({v.name, ".no_res_gap"}, 32'(bus.res_valid), 32'd0);
                end
            end
            bus.op_valid = 1'b1;
            bus.op_a     = v.a[i];
            bus.op_b     = v.b[i];
            tick();
            bus.op_valid = 1'b0;
        end

        waited = 0;
        while (!bus.res_valid && waited < 8) begin
            tick();
            waited++;
        end
        check({v.name, ".latency"}, 32'(waited), 32'd0);
        if (exp_q.size() == 0) begin
            check({v.name, ".scoreboard_empty"}, 32'd1, 32'd0);
            e = '{res: '0, sat: 1'b0};
        end else begin
            e = exp_q.pop_front();
        end
        check({v.name, ".result"}, bus.result, e.res);
        check({v.name, ".sat_flag"}, 32'(sat_flag), 32'(e.sat));
        check({v.name, ".ready_done"}, 32'(bus.op_ready), 32'd0);
        check({v.name, ".busy_done"}, 32'(busy), 32'd1);

        for (int k = 0; k < v.stall; k++) begin
            if (v.start_in_done && k == 1) start = 1'b1;
            tick();
            start = 1'b0;
            check({v.name, ".hold_valid"}, 32'(bus.res_valid), 32'd1);
            check({v.name, ".hold_result"}, bus.result, e.res);
        end

        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({v.name, ".valid_drop"}, 32'(bus.res_valid), 32'd0);
        check({v.name, ".busy_idle"}, 32'(busy), 32'd0);
        check({v.name, ".result_kept"}, bus.result, e.res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0] = '{name: "basic", a: {32'd1, 32'd3, 32'd5, 32'd7}, b: {32'd2, 32'd4, 32'd6, 32'd8},
                   gap: 0, stall: 0, start_in_done: 1'b0, collide: 1'b0, exp_res: 32'd100, exp_sat: 1'b0};
        tbl[1] = '{name: "signed_gap", a: {32'(-3), 32'd4, 32'(-1), 32'd10},
                   b: {32'd5, 32'(-2), 32'(-1), 32'd1},
                   gap: 3, stall: 0, start_in_done: 1'b0, collide: 1'b0, exp_res: 32'hFFFF_FFF4, exp_sat: 1'b0};
        tbl[2] = '{name: "backpressure", a: {32'd1, 32'd3, 32'd5, 32'd7}, b: {32'd2, 32'd4, 32'd6, 32'd8},
                   gap: 0, stall: 5, start_in_done: 1'b1, collide: 1'b0, exp_res: 32'd100, exp_sat: 1'b0};
`ifdef MAC_SAT_EN
        tbl[3] = '{name: "overflow", a: {32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0}, b: {32'd1, 32'd1, 32'd0, 32'd0},
                   gap: 0, stall: 0, start_in_done: 1'b0, collide: 1'b0, exp_res: 32'h7FFF_FFFF, exp_sat: 1'b1};
`else
        tbl[3] = '{name: "overflow", a: {32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0}, b: {32'd1, 32'd1, 32'd0, 32'd0},
                   gap: 0, stall: 0, start_in_done: 1'b0, collide: 1'b0, exp_res: 32'h8000_0000, exp_sat: 1'b0};
`endif
        tbl[4] = '{name: "collide", a: {32'd1, 32'd1, 32'd1, 32'd1}, b: {32'd1, 32'd1, 32'd1, 32'd1},
                   gap: 0, stall: 0, start_in_done: 1'b0, collide: 1'b1, exp_res: 32'd4, exp_sat: 1'b0};

        rst_n         = 1'b0;
        start         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b0;
        repeat (2) tick();
        check("reset.op_ready", 32'(bus.op_ready), 32'd0);
        check("reset.res_valid", 32'(bus.res_valid), 32'd0);
        check("reset.result", bus.result, 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.sat_flag", 32'(sat_flag), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 5; t++) run_dot(tbl[t]);

        // Reset after two of four pairs abandons the dot product and clears result.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a     = 32'd2;
            bus.op_b     = 32'd2;
            tick();
        end
        bus.op_valid = 1'b0;
        rst_n        = 1'b0;
        tick();
        check("midreset.op_ready", 32'(bus.op_ready), 32'd0);
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.res_valid", 32'(bus.res_valid), 32'd0);
        check("midreset.result", bus.result, 32'd0);
        rst_n = 1'b1;
        tick();

        v = '{name: "after_reset", a: {32'd2, 32'd2, 32'd2, 32'd2}, b: {32'd2, 32'd2, 32'd2, 32'd2},
              gap: 0, stall: 0, start_in_done: 1'b0, collide: 1'b0, exp_res: 32'd16, exp_sat: 1'b0};
        run_dot(v);

        check("scoreboard.drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
